// File: rtl/smc_row_pkg.sv
// rtl/smc_row_pkg.sv - op encodings and FSM state type for the SMC row sequencer
package smc_row_pkg;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_RD  = 2'b01,
    OP_CLR = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR0,
    S_SH_SET,
    S_SH_PLS,
    S_REQ,
    S_WL,
    S_GAP,
    S_FILL_SET,
    S_FILL_PLS,
    S_CRST,
    S_CLR1,
    S_FIN
  } row_state_e;

endpackage

// File: rtl/smc_dwell_cnt.sv
// rtl/smc_dwell_cnt.sv - load / count-down dwell counter with current and next zero flags
module smc_dwell_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         next_zero
);

  logic [W-1:0] count;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count != '0)) begin
      count_d = count - W'(1);
    end
  end

  // next_zero lets the owner register a pulse that lands in the final dwell cycle
  assign zero      = (count == '0);
  assign next_zero = (count_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/smc_row_seq.sv
// rtl/smc_row_seq.sv - walks one token down the row-select chain and strobes wordlines / frame clear
module smc_row_seq
  import smc_row_pkg::*;
#(
  parameter  int NUM_ROWS = 16,
  parameter  int WRT_CYC  = 4,
  localparam int ROW_W    = $clog2(NUM_ROWS)
) (
  input  logic             smc_clk,
  input  logic             smc_rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  output logic             row_req,
  input  logic             row_ack,
  output logic             rd_sample,
  input  logic             smc_rsr_last,
  output logic             smc_rsr_in,
  output logic             smc_rsr_inc,
  output logic             rsr_rst,
  output logic             smc_write,
  output logic             cram_wl_en,
  output logic             cram_rst,
  output logic [ROW_W-1:0] row_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int               CNT_W    = $clog2(WRT_CYC + 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(WRT_CYC - 1);

  row_state_e       state, state_d;
  op_e              op_q, op_d;
  logic             wl_first, wl_first_d;
  logic [ROW_W-1:0] row_idx_d;
  logic             err_d;
  logic             row_req_d, rd_sample_d, rsr_in_d, rsr_inc_d, rsr_rst_d;
  logic             write_d, wl_en_d, cram_rst_d, busy_d, done_d;
  logic             dwell_load, dwell_dec, dwell_zero, dwell_next_zero;

  smc_dwell_cnt #(.W(CNT_W)) u_dwell (
    .clk       (smc_clk),
    .rst       (smc_rst),
    .load      (dwell_load),
    .load_val  (DWELL_LD),
    .dec       (dwell_dec),
    .zero      (dwell_zero),
    .next_zero (dwell_next_zero)
  );

  always_comb begin
    state_d   = state;
    op_d      = op_q;
    row_idx_d = row_idx;
    err_d     = err;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (op_e'(op) == OP_RSV) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            op_d      = op_e'(op);
            err_d     = 1'b0;
            row_idx_d = '0;
            state_d   = S_CLR0;
          end
        end
      end
      S_CLR0:   state_d = (op_q == OP_CLR) ? S_FILL_SET : S_SH_SET;
      S_SH_SET: state_d = S_SH_PLS;
      S_SH_PLS: state_d = S_REQ;
      S_REQ:    if (row_ack) state_d = S_WL;
      S_WL: begin
        // token must sit at the chain end only while the final row is selected
        if (wl_first && ((row_idx == LAST_ROW) != smc_rsr_last)) err_d = 1'b1;
        if (dwell_zero) state_d = S_GAP;
      end
      S_GAP: begin
        if (row_idx < LAST_ROW) begin
          row_idx_d = row_idx + ROW_W'(1);
          state_d   = S_SH_SET;
        end else begin
          state_d = S_CLR1;
        end
      end
      S_FILL_SET: state_d = S_FILL_PLS;
      S_FILL_PLS: begin
        if (row_idx < LAST_ROW) begin
          row_idx_d = row_idx + ROW_W'(1);
          state_d   = S_FILL_SET;
        end else begin
          state_d = S_CRST;
        end
      end
      S_CRST:  if (dwell_zero) state_d = S_CLR1;
      S_CLR1:  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state != S_IDLE) && (state != S_FIN)) begin
      err_d = 1'b1;
      if (state != S_CLR1) state_d = S_CLR1;
    end

    wl_first_d = (state_d == S_WL) && (state != S_WL);
    dwell_load = ((state_d == S_WL) && (state != S_WL)) ||
                 ((state_d == S_CRST) && (state != S_CRST));
    dwell_dec  = ((state == S_WL) || (state == S_CRST)) && (state_d == state);

    // outputs are decoded from the state being entered and then registered
    row_req_d   = (state_d == S_REQ);
    wl_en_d     = (state_d == S_WL);
    write_d     = (state_d == S_WL) && (op_q == OP_WR);
    rd_sample_d = (state_d == S_WL) && (op_q == OP_RD) && dwell_next_zero;
    rsr_inc_d   = (state_d == S_SH_PLS) || (state_d == S_FILL_PLS);
    rsr_in_d    = (((state_d == S_SH_SET) || (state_d == S_SH_PLS)) && (row_idx_d == '0)) ||
                  (state_d == S_FILL_SET) || (state_d == S_FILL_PLS);
    rsr_rst_d   = (state_d == S_CLR0) || (state_d == S_CLR1);
    cram_rst_d  = (state_d == S_CRST);
    busy_d      = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d      = (state_d == S_FIN);
  end

  always_ff @(posedge smc_clk) begin
    if (smc_rst) begin
      state       <= S_IDLE;
      op_q        <= OP_WR;
      wl_first    <= 1'b0;
      row_idx     <= '0;
      err         <= 1'b0;
      row_req     <= 1'b0;
      rd_sample   <= 1'b0;
      smc_rsr_in  <= 1'b0;
      smc_rsr_inc <= 1'b0;
      rsr_rst     <= 1'b0;
      smc_write   <= 1'b0;
      cram_wl_en  <= 1'b0;
      cram_rst    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      wl_first    <= wl_first_d;
      row_idx     <= row_idx_d;
      err         <= err_d;
      row_req     <= row_req_d;
      rd_sample   <= rd_sample_d;
      smc_rsr_in  <= rsr_in_d;
      smc_rsr_inc <= rsr_inc_d;
      rsr_rst     <= rsr_rst_d;
      smc_write   <= write_d;
      cram_wl_en  <= wl_en_d;
      cram_rst    <= cram_rst_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_smc_row_seq.sv
// tb/tb_smc_row_seq.sv - directed bench for smc_row_seq with a 4-row RSR chain model
module tb_smc_row_seq;

  logic       smc_clk = 1'b0;
  logic       smc_rst = 1'b1;
  logic       start   = 1'b0;
  logic [1:0] op      = 2'b00;
  logic       abort   = 1'b0;
  logic       row_ack = 1'b1;
  logic       smc_rsr_last;
  logic       row_req, rd_sample, smc_rsr_in, smc_rsr_inc, rsr_rst;
  logic       smc_write, cram_wl_en, cram_rst, busy, done, err;
  logic [1:0] row_idx;

  logic [3:0] rsr   = 4'b0000;
  logic       stuck = 1'b0;
  int         ack_delay = 0;
  int         req_k = 0;

  int n_checks = 0;
  int n_pass   = 0;

  int n_rsr_rst, n_inc, n_inc_in1, n_wl, n_wr_wl, n_write, n_rd, n_rd_2nd;
  int n_req, n_req_runs, n_crst, wl_run, req_run;
  logic [3:0] crst_rsr;
  int   lat;
  logic err_at_done, busy_at_done;
  logic [1:0] row_at_done;

  smc_row_seq #(.NUM_ROWS(4), .WRT_CYC(2)) dut (
    .smc_clk      (smc_clk),
    .smc_rst      (smc_rst),
    .start        (start),
    .op           (op),
    .abort        (abort),
    .row_req      (row_req),
    .row_ack      (row_ack),
    .rd_sample    (rd_sample),
    .smc_rsr_last (smc_rsr_last),
    .smc_rsr_in   (smc_rsr_in),
    .smc_rsr_inc  (smc_rsr_inc),
    .rsr_rst      (rsr_rst),
    .smc_write    (smc_write),
    .cram_wl_en   (cram_wl_en),
    .cram_rst     (cram_rst),
    .row_idx      (row_idx),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 smc_clk = ~smc_clk;

  // chain of four row-driver flops clocked by the shift strobe
  always @(posedge smc_rsr_inc or posedge rsr_rst) begin
    if (rsr_rst) rsr <= 4'b0000;
    else         rsr <= {rsr[2:0], smc_rsr_in};
  end
  assign smc_rsr_last = stuck ? 1'b0 : rsr[3];

  always @(negedge smc_clk) begin
    if (ack_delay == 0) begin
      row_ack = 1'b1;
    end else if (row_req) begin
      req_k   = req_k + 1;
      row_ack = (req_k >= ack_delay);
    end else begin
      req_k   = 0;
      row_ack = 1'b0;
    end
  end

  always @(negedge smc_clk) begin
    if (rsr_rst) n_rsr_rst++;
    if (smc_rsr_inc) begin
      n_inc++;
      if (smc_rsr_in) n_inc_in1++;
    end
    if (cram_wl_en) begin
      wl_run++;
      n_wl++;
      if (smc_write) n_wr_wl++;
    end else begin
      wl_run = 0;
    end
    if (smc_write) n_write++;
    if (rd_sample) begin
      n_rd++;
      if (wl_run == 2) n_rd_2nd++;
    end
    if (row_req) begin
      n_req++;
      req_run++;
    end else if (req_run != 0) begin
      n_req_runs++;
      req_run = 0;
    end
    if (cram_rst) begin
      if (n_crst == 0) crst_rsr = rsr;
      n_crst++;
    end
  end

  always @(negedge smc_clk) begin
    if (!smc_rst) begin
      assert (!(smc_rsr_inc && cram_wl_en))
        else $error("FAIL inc_wl_overlap inc=%0b wl_en=%0b", smc_rsr_inc, cram_wl_en);
      assert (!(done && busy))
        else $error("FAIL busy_at_done busy=%0b done=%0b", busy, done);
      assert (!(smc_write && !cram_wl_en))
        else $error("FAIL write_without_wl write=%0b wl_en=%0b", smc_write, cram_wl_en);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_stats();
    n_rsr_rst = 0; n_inc = 0; n_inc_in1 = 0; n_wl = 0; n_wr_wl = 0; n_write = 0;
    n_rd = 0; n_rd_2nd = 0; n_req = 0; n_req_runs = 0; n_crst = 0;
    wl_run = 0; req_run = 0; crst_rsr = 4'b0000;
  endtask

  task automatic run_op(input logic [1:0] o, input string tag);
    logic got;
    got   = 1'b0;
    clear_stats();
    op    = o;
    start = 1'b1;
    lat   = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge smc_clk);
      start = 1'b0;
      lat++;
      if (done) begin
        got          = 1'b1;
        err_at_done  = err;
        busy_at_done = busy;
        row_at_done  = row_idx;
        break;
      end
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
    @(negedge smc_clk);
    @(negedge smc_clk);
  endtask

  task automatic wait_done(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge smc_clk);
      if (done) begin
        got         = 1'b1;
        err_at_done = err;
        break;
      end
    end
    check({tag, "_done_seen"}, int'(got), 1);
  endtask

  initial begin
    logic found;
    int   k;
    clear_stats();
    repeat (3) @(negedge smc_clk);
    check("reset_outputs", int'({row_req, rd_sample, smc_rsr_in, smc_rsr_inc, rsr_rst, smc_write,
                                 cram_wl_en, cram_rst, row_idx, busy, done, err}), 0);
    smc_rst = 1'b0;
    @(negedge smc_clk);

    // write with row_ack tied high
    ack_delay = 0;
    run_op(2'b00, "wr");
    check("wr_rsr_rst",   n_rsr_rst, 2);
    check("wr_inc",       n_inc, 4);
    check("wr_inc_in1",   n_inc_in1, 1);
    check("wr_wl_write",  n_wr_wl, 8);
    check("wr_wl",        n_wl, 8);
    check("wr_req",       n_req, 4);
    check("wr_err",       int'(err_at_done), 0);
    check("wr_row_idx",   int'(row_at_done), 3);
    check("wr_chain_end", int'(rsr), 0);

    // read with row_ack arriving on the 3rd row_req cycle
    ack_delay = 3;
    run_op(2'b01, "rd");
    check("rd_req_cycles", n_req, 12);
    check("rd_req_runs",   n_req_runs, 4);
    check("rd_sample",     n_rd, 4);
    check("rd_sample_2nd", n_rd_2nd, 4);
    check("rd_write",      n_write, 0);
    check("rd_wl",         n_wl, 8);
    check("rd_err",        int'(err_at_done), 0);
    ack_delay = 0;

    // frame clear
    run_op(2'b10, "clr");
    check("clr_inc",       n_inc, 4);
    check("clr_inc_in1",   n_inc_in1, 4);
    check("clr_chain_full", int'(crst_rsr), 15);
    check("clr_cram_rst",  n_crst, 2);
    check("clr_rsr_rst",   n_rsr_rst, 2);
    check("clr_wl",        n_wl, 0);
    check("clr_chain_end", int'(rsr), 0);
    check("clr_err",       int'(err_at_done), 0);

    // last chain bit stuck low
    stuck = 1'b1;
    run_op(2'b00, "brk");
    check("brk_err", int'(err_at_done), 1);
    stuck = 1'b0;

    // reserved op
    run_op(2'b11, "rsv");
    check("rsv_latency", lat, 1);
    check("rsv_err",     int'(err_at_done), 1);
    check("rsv_busy",    int'(busy_at_done), 0);
    check("rsv_chain",   n_inc + n_rsr_rst, 0);

    // abort in the 2nd wordline cycle of row 1
    op    = 2'b00;
    start = 1'b1;
    @(negedge smc_clk);
    start = 1'b0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < 200; i++) begin
      if (cram_wl_en && (row_idx == 2'd1)) begin
        k++;
        if (k == 2) begin
          found = 1'b1;
          break;
        end
      end
      @(negedge smc_clk);
    end
    check("abt_reach", int'(found), 1);
    abort = 1'b1;
    @(negedge smc_clk);
    abort = 1'b0;
    check("abt_wl_drop",    int'({cram_wl_en, smc_write}), 0);
    check("abt_rsr_rst",    int'(rsr_rst), 1);
    wait_done("abt");
    check("abt_err", int'(err_at_done), 1);
    @(negedge smc_clk);

    // synchronous reset while the first shift strobe is high
    op    = 2'b00;
    start = 1'b1;
    @(negedge smc_clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (smc_rsr_inc) begin
        found = 1'b1;
        break;
      end
      @(negedge smc_clk);
    end
    check("rst_reach", int'(found), 1);
    smc_rst = 1'b1;
    @(negedge smc_clk);
    check("rst_mid_outputs", int'({row_req, rd_sample, smc_rsr_in, smc_rsr_inc, rsr_rst, smc_write,
                                   cram_wl_en, cram_rst, row_idx, busy, done, err}), 0);
    smc_rst = 1'b0;
    @(negedge smc_clk);
    run_op(2'b00, "wr2");
    check("wr2_inc",      n_inc, 4);
    check("wr2_inc_in1",  n_inc_in1, 1);
    check("wr2_wl_write", n_wr_wl, 8);
    check("wr2_err",      int'(err_at_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
